// File: rtl/wb_uart_rx_if.sv
// rtl/wb_uart_rx_if.sv - serial-in / byte-out signal bundle for wb_uart_rx; o_break exists only under UART_RX_BREAK_DETECT_EN
interface wb_uart_rx_if;
  logic       i_uart_rx;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_BREAK_DETECT_EN
  logic       o_break;

  modport master (
    input  i_uart_rx,
    output o_wr, o_data, o_frame_err, o_busy, o_break
  );
  modport slave (
    output i_uart_rx,
    input  o_wr, o_data, o_frame_err, o_busy, o_break
  );
`else
  modport master (
    input  i_uart_rx,
    output o_wr, o_data, o_frame_err, o_busy
  );
  modport slave (
    output i_uart_rx,
    input  o_wr, o_data, o_frame_err, o_busy
  );
`endif
endinterface

// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - 8N1 UART receiver with mid-bit sampling; UART_RX_BREAK_DETECT_EN adds o_break
module wb_uart_rx #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd217
) (
  input logic          i_clk,
  input logic          i_reset,
  wb_uart_rx_if.master rx
);

  localparam logic [23:0] HALF_LOAD = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_LOAD = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

  state_t      state, state_next;
  logic [1:0]  sync;
  logic        line;
  logic [23:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_next;
  logic [7:0]  shift, shift_next;
  logic [7:0]  data_q, data_next;
  logic        wr_q, wr_next;
  logic        ferr_q, ferr_next;
`ifdef UART_RX_BREAK_DETECT_EN
  logic        brk_q, brk_next;
`endif

  assign line = sync[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      sync    <= 2'b11;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q   <= 1'b0;
`endif
    end else begin
      state   <= state_next;
      sync    <= {sync[0], rx.i_uart_rx};
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      data_q  <= data_next;
      wr_q    <= wr_next;
      ferr_q  <= ferr_next;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_q   <= brk_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    data_next  = data_q;
    wr_next    = 1'b0;
    ferr_next  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    brk_next   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!line) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == 24'd0) begin
          // A high line at mid-start means a glitch, not a frame
          if (line) begin
            state_next = IDLE;
          end else begin
            state_next = DATA;
            cnt_next   = FULL_LOAD;
            bit_next   = 3'd0;
          end
        end else begin
          cnt_next = cnt - 24'd1;
        end
      end
      DATA: begin
        if (cnt == 24'd0) begin
          shift_next = {line, shift[7:1]};
          cnt_next   = FULL_LOAD;
          bit_next   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt - 24'd1;
        end
      end
      STOP: begin
        if (cnt == 24'd0) begin
          if (line) begin
            wr_next    = 1'b1;
            data_next  = shift;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_next   = (shift == 8'h00);
`endif
            cnt_next   = FULL_LOAD;
            state_next = RECOVER;
          end
        end else begin
          cnt_next = cnt - 24'd1;
        end
      end
      RECOVER: begin
        // Needs a full bit period of continuous high; any low restarts it
        if (!line) begin
          cnt_next = FULL_LOAD;
        end else if (cnt == 24'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 24'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx.o_wr        = wr_q;
  assign rx.o_data      = data_q;
  assign rx.o_frame_err = ferr_q;
  assign rx.o_busy      = (state != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
  assign rx.o_break     = brk_q;
`endif

endmodule

// File: tb/tb_wb_uart_rx.sv
// tb/tb_wb_uart_rx.sv - directed self-checking bench for wb_uart_rx at CLOCKS_PER_BAUD=16
module tb_wb_uart_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int         wr_count = 0;
  int         ferr_count = 0;
  int         both_count = 0;
  int         wr_cyc = 0;
  int         ferr_cyc = 0;
  logic [7:0] rx_bytes [0:63];
`ifdef UART_RX_BREAK_DETECT_EN
  int         brk_count = 0;
  int         brk_ferr = 0;
`endif

  wb_uart_rx_if bus();

  wb_uart_rx #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .rx     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_wr) begin
      if (wr_count < 64) rx_bytes[wr_count] <= bus.o_data;
      wr_count <= wr_count + 1;
      wr_cyc   <= cyc;
    end
    if (bus.o_frame_err) begin
      ferr_count <= ferr_count + 1;
      ferr_cyc   <= cyc;
    end
    if (bus.o_wr && bus.o_frame_err) both_count <= both_count + 1;
`ifdef UART_RX_BREAK_DETECT_EN
    if (bus.o_break) brk_count <= brk_count + 1;
    if (bus.o_break && bus.o_frame_err) brk_ferr <= brk_ferr + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; t0 is the rising edge that first sees the start bit
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    t0 = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      bus.i_uart_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    bus.i_uart_rx = 1'b1;
  endtask

  initial begin
    int t0;
    int wr_base;
    int ferr_base;
    logic [7:0] msg [0:14];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
            8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    bus.i_uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_wr", {31'd0, bus.o_wr}, 32'd0);
    chk("reset_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("reset_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("reset_data", {24'd0, bus.o_data}, 32'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single 'H': strobe leaves the stop-sample edge t0+154, seen by edge t0+155
    send_frame(8'h48, 1'b1, t0);
    repeat (4) @(negedge clk);
    chk("h_count", wr_count, 32'd1);
    chk("h_cycle", wr_cyc, t0 + 154);
    chk("h_data", {24'd0, bus.o_data}, 32'h48);
    chk("h_ferr", ferr_count, 32'd0);
    chk("h_busy", {31'd0, bus.o_busy}, 32'd0);

    wr_base = wr_count;
    for (int i = 0; i < 15; i++) send_frame(msg[i], 1'b1, t0);
    repeat (2 * CPB) @(negedge clk);
    chk("hello_count", wr_count - wr_base, 32'd15);
    for (int i = 0; i < 15; i++) chk("hello_byte", {24'd0, rx_bytes[wr_base + i]}, {24'd0, msg[i]});
    chk("hello_ferr", ferr_count, 32'd0);

    // Five-cycle glitch: START at t0+2, rejected at the start sample t0+10
    wr_base = wr_count;
    bus.i_uart_rx = 1'b0;
    t0 = cyc + 1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_t1", {31'd0, bus.o_busy}, 32'd0);
    repeat (1) @(negedge clk);
    chk("glitch_busy_t2", {31'd0, bus.o_busy}, 32'd1);
    repeat (2) @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch_busy_t9", {31'd0, bus.o_busy}, 32'd1);
    repeat (1) @(negedge clk);
    chk("glitch_busy_t10", {31'd0, bus.o_busy}, 32'd0);
    repeat (CPB) @(negedge clk);
    chk("glitch_wr", wr_count - wr_base, 32'd0);
    chk("glitch_ferr", ferr_count, 32'd0);

    // 8'hA5 with a low stop bit, then a one-cycle dip during RECOVER
    wr_base = wr_count;
    ferr_base = ferr_count;
    send_frame(8'hA5, 1'b0, t0);
    chk("ferr_count", ferr_count - ferr_base, 32'd1);
    chk("ferr_cycle", ferr_cyc, t0 + 154);
    chk("ferr_wr", wr_count - wr_base, 32'd0);
    chk("ferr_data_held", {24'd0, bus.o_data}, 32'h0A);
    chk("ferr_busy", {31'd0, bus.o_busy}, 32'd1);
    repeat (8) @(negedge clk);
    bus.i_uart_rx = 1'b0;
    repeat (1) @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (9) @(negedge clk);
    chk("recover_restart", {31'd0, bus.o_busy}, 32'd1);
    repeat (8) @(negedge clk);
    chk("recover_last", {31'd0, bus.o_busy}, 32'd1);
    repeat (1) @(negedge clk);
    chk("recover_done", {31'd0, bus.o_busy}, 32'd0);
    send_frame(8'h3C, 1'b1, t0);
    repeat (4) @(negedge clk);
    chk("after_ferr_count", wr_count - wr_base, 32'd1);
    chk("after_ferr_data", {24'd0, bus.o_data}, 32'h3C);
    chk("after_ferr_ferr", ferr_count - ferr_base, 32'd1);

    // Reset during data bit 4 of 8'hFF
    wr_base = wr_count;
    bus.i_uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (4 * CPB + 5) @(negedge clk);
    rst = 1'b1;
    repeat (1) @(negedge clk);
    chk("midrst_wr", {31'd0, bus.o_wr}, 32'd0);
    chk("midrst_ferr", {31'd0, bus.o_frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    chk("midrst_data", {24'd0, bus.o_data}, 32'h00);
    rst = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    chk("midrst_nostrobe", wr_count - wr_base, 32'd0);
    chk("midrst_noferr", ferr_count - ferr_base, 32'd1);
    send_frame(8'h0F, 1'b1, t0);
    repeat (4) @(negedge clk);
    chk("post_rst_count", wr_count - wr_base, 32'd1);
    chk("post_rst_data", {24'd0, bus.o_data}, 32'h0F);

    // Line low for 12 bit times
    wr_base = wr_count;
    ferr_base = ferr_count;
    bus.i_uart_rx = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    bus.i_uart_rx = 1'b1;
    repeat (24) @(negedge clk);
    chk("brk_ferr_count", ferr_count - ferr_base, 32'd1);
    chk("brk_wr", wr_count - wr_base, 32'd0);
    chk("brk_data_held", {24'd0, bus.o_data}, 32'h0F);
    chk("brk_busy", {31'd0, bus.o_busy}, 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("brk_count", brk_count, 32'd1);
    chk("brk_with_ferr", brk_ferr, 32'd1);
`endif
    chk("wr_ferr_exclusive", both_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_uart_rx.md
WB_UART_RX -- requirements
Module: wb_uart_rx

Interface
REQ-001 The block SHALL have parameter CLOCKS_PER_BAUD, 24 bits, default 217, clocks per UART bit period (legal range 4..2^24-1).
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port i_uart_rx, input, 1 bit, asynchronous serial line, idle high.
REQ-005 The block SHALL have port o_wr, output, 1 bit, one-cycle strobe indicating o_data holds a valid received byte.
REQ-006 The block SHALL have port o_data, output, 8 bits, last received byte.
REQ-007 The block SHALL have port o_frame_err, output, 1 bit, one-cycle strobe indicating a stop bit was sampled low.
REQ-008 The block SHALL have port o_busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-009 i_uart_rx SHALL pass through a two-flop synchronizer (reset value 1) before any use.
REQ-010 FSM states SHALL be IDLE, START, DATA, STOP, RECOVER.
REQ-011 IDLE SHALL go to START when the synchronized line is low, loading the baud counter with CLOCKS_PER_BAUD/2 - 1 (integer division).
REQ-012 Let t0 be the first edge at which i_uart_rx is sampled low; then START is entered at edge t0+2, start sample at t0+2+CLOCKS_PER_BAUD/2, data bit k (k=0..7, LSB first) at start sample + (k+1)*CLOCKS_PER_BAUD, stop sample at start sample + 9*CLOCKS_PER_BAUD.
REQ-013 Start sample high (false start/glitch) SHALL return to IDLE with no output strobe.
REQ-014 After the start sample, the baud counter SHALL reload CLOCKS_PER_BAUD-1 and decrement to 0 for each following sample; a 3-bit bit index SHALL count data bits 0..7.
REQ-015 Data bits SHALL shift into an 8-bit register LSB first; o_data SHALL update only when o_wr asserts and hold otherwise.
REQ-016 Stop sample high SHALL assert o_wr for exactly one cycle following that edge and return to IDLE the same edge, allowing back-to-back frames with no idle gap.
REQ-017 Stop sample low SHALL assert o_frame_err for one cycle, SHALL NOT assert o_wr or update o_data, and SHALL enter RECOVER.
REQ-018 RECOVER SHALL return to IDLE only after the synchronized line has been high for one full CLOCKS_PER_BAUD period; a low during that period restarts the count.
REQ-019 o_wr and o_frame_err SHALL never both be high in the same cycle.
REQ-020 Line activity while in a non-IDLE state SHALL not reset the frame; only the sampling points defined in REQ-012 matter.

Reset
REQ-021 i_reset high at any edge, including mid-frame, SHALL force IDLE, counter 0, bit index 0, synchronizer 2'b11, o_wr=0, o_frame_err=0, o_busy=0, o_data=8'h00.
REQ-022 A frame interrupted by reset SHALL produce no strobe; reception resumes at the next falling edge after reset deasserts.

Configuration
REQ-023 Macro UART_RX_BREAK_DETECT_EN SHALL, when defined, add output o_break (1 bit, reset 0) asserted for one cycle when a frame completes with all data bits 0 and stop bit 0; o_frame_err is still asserted in that cycle.
REQ-024 Without UART_RX_BREAK_DETECT_EN, port o_break and its logic SHALL not exist; all other behaviour is identical.

Verification
REQ-025 CLOCKS_PER_BAUD=16, send 8'h48 ('H') with one stop bit -> o_wr high one cycle at t0+2+8+144+1, o_data=8'h48, o_frame_err never high.
REQ-026 CLOCKS_PER_BAUD=16, send "Hello, World!\r\n" back-to-back (no idle between frames) -> 15 o_wr strobes with the exact byte sequence, no frame errors.
REQ-027 Line low for 5 cycles then high (glitch), CLOCKS_PER_BAUD=16 -> return to IDLE at start sample, no o_wr, no o_frame_err, o_busy low afterward.
REQ-028 Send 8'hA5 with stop bit forced low -> o_frame_err one cycle, no o_wr, o_data unchanged; FSM stays in RECOVER until line high for 16 cycles, then a following 8'h3C is received correctly.
REQ-029 Assert i_reset during data bit 4 of 8'hFF -> all outputs 0 next cycle, no strobe; next frame 8'h0F is received correctly.
REQ-030 With UART_RX_BREAK_DETECT_EN, hold line low for 12 bit times -> o_break and o_frame_err high in the same single cycle, no o_wr; without the macro, the same stimulus yields o_frame_err only.
